// File: rtl/guess_history_pkg.sv
// Shared game constants for the guess-history blocks.
// Peg vectors pack peg 0 into the least-significant W bits.
package guess_history_pkg;

  localparam int GAME_DEPTH = 8;
  localparam int GAME_W     = 3;
  localparam int GAME_PEGS  = 4;

endpackage

// File: rtl/guess_history_btn_edge.sv
// Registered rising-edge detector for one push button.
// The pulse is high for exactly one cycle per press, however long the button is held.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) btn_q <= 1'b0;
    else        btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/guess_history.sv
// Stores up to DEPTH committed four-peg guesses.
// Shows either the live guess (mode 0) or a browsable stored turn (mode 1).
module guess_history
  import guess_history_pkg::*;
#(
  parameter int DEPTH = GAME_DEPTH,
  parameter int W     = GAME_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mode,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_select,
  input  logic [W-1:0]               guess0,
  input  logic [W-1:0]               guess1,
  input  logic [W-1:0]               guess2,
  input  logic [W-1:0]               guess3,
  output logic [W-1:0]               selection0,
  output logic [W-1:0]               selection1,
  output logic [W-1:0]               selection2,
  output logic [W-1:0]               selection3,
  output logic [$clog2(DEPTH)-1:0]   selected_turn,
  output logic                       last_turn
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int VW = $clog2(DEPTH);

  logic [GAME_PEGS-1:0][W-1:0] mem [DEPTH];
  logic [GAME_PEGS-1:0][W-1:0] guess_vec;
  logic [GAME_PEGS-1:0][W-1:0] shown;
  logic [CW-1:0]               count;
  logic [VW-1:0]               view;
  logic [VW-1:0]               newest;
  logic                        mode_q;
  logic                        full;
  logic                        up_rise, down_rise, sel_rise;

  btn_edge u_up   (.clk(clk), .reset(reset), .btn(btn_up),     .rise(up_rise));
  btn_edge u_down (.clk(clk), .reset(reset), .btn(btn_down),   .rise(down_rise));
  btn_edge u_sel  (.clk(clk), .reset(reset), .btn(btn_select), .rise(sel_rise));

  assign guess_vec = {guess3, guess2, guess1, guess0};
  assign full      = (count == CW'(DEPTH));
  assign last_turn = full;

  // Index of the most recent stored turn, 0 when nothing is stored.
  always_comb begin
    newest = '0;
    if (count != '0) newest = VW'(count - CW'(1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      view   <= '0;
      mode_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mode_q <= mode;
      if (!mode) begin
        if (sel_rise && !full) begin
          mem[count[VW-1:0]] <= guess_vec;
          count              <= count + 1'b1;
        end
      end else if (!mode_q) begin
        view <= newest;
      end else if (up_rise && !down_rise) begin
        if (view < newest) view <= view + 1'b1;
      end else if (down_rise && !up_rise) begin
        if (view != '0) view <= view - 1'b1;
      end
    end
  end

  always_comb begin
    shown         = guess_vec;
    selected_turn = full ? VW'(DEPTH - 1) : count[VW-1:0];
    if (mode) begin
      if (count == '0) begin
        shown         = '0;
        selected_turn = '0;
      end else begin
        shown         = mem[view];
        selected_turn = view;
      end
    end
  end

  assign selection0 = shown[0];
  assign selection1 = shown[1];
  assign selection2 = shown[2];
  assign selection3 = shown[3];

endmodule

// File: tb/tb_guess_history.sv
// Bench for guess_history: a turn-list model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_guess_history;

  localparam int DEPTH = 8;
  localparam int W     = 3;
  localparam int SW    = 4 * W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic mode = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_select = 1'b0;
  logic [W-1:0] guess0 = '0, guess1 = '0, guess2 = '0, guess3 = '0;
  logic [W-1:0] selection0, selection1, selection2, selection3;
  logic [2:0]   selected_turn;
  logic         last_turn;

  int total = 0;
  int bad   = 0;

  // Model state: list of committed guesses, browse index, previous input samples.
  logic [SW-1:0] exp_q[$];
  int   m_view = 0;
  logic p_up = 0, p_down = 0, p_sel = 0, p_mode = 0;

  guess_history #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .reset(reset), .mode(mode),
    .btn_up(btn_up), .btn_down(btn_down), .btn_select(btn_select),
    .guess0(guess0), .guess1(guess1), .guess2(guess2), .guess3(guess3),
    .selection0(selection0), .selection1(selection1),
    .selection2(selection2), .selection3(selection3),
    .selected_turn(selected_turn), .last_turn(last_turn)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit (actual running, required finished)");
    $fatal(1, "timeout");
  end

  function automatic logic [SW-1:0] pack(int a, int b, int c, int d);
    logic [W-1:0] p0, p1, p2, p3;
    p0 = W'(a); p1 = W'(b); p2 = W'(c); p3 = W'(d);
    return {p3, p2, p1, p0};
  endfunction

  function automatic logic [SW-1:0] dut_sel();
    return {selection3, selection2, selection1, selection0};
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Model update, one step per clock edge; reset empties the turn list at once.
  task automatic model_step();
    logic up_r, dn_r, sel_r;
    if (!reset) begin
      exp_q.delete();
      m_view = 0;
      p_up = 0; p_down = 0; p_sel = 0; p_mode = 0;
      return;
    end
    up_r  = btn_up && !p_up;
    dn_r  = btn_down && !p_down;
    sel_r = btn_select && !p_sel;
    if (!mode) begin
      if (sel_r && exp_q.size() < DEPTH)
        exp_q.push_back(pack(guess0, guess1, guess2, guess3));
    end else if (!p_mode) begin
      m_view = (exp_q.size() > 0) ? exp_q.size() - 1 : 0;
    end else if (up_r && !dn_r) begin
      if (m_view < int'(exp_q.size()) - 1) m_view++;
    end else if (dn_r && !up_r) begin
      if (m_view > 0) m_view--;
    end
    p_up = btn_up; p_down = btn_down; p_sel = btn_select; p_mode = mode;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      model_step();
    end
  end

  task automatic compare_model();
    logic [SW-1:0] e_sel;
    int e_turn, n;
    n = exp_q.size();
    if (!mode) begin
      e_sel  = pack(guess0, guess1, guess2, guess3);
      e_turn = (n < DEPTH) ? n : DEPTH - 1;
    end else if (n == 0) begin
      e_sel  = '0;
      e_turn = 0;
    end else begin
      e_sel  = exp_q[m_view];
      e_turn = m_view;
    end
    check("model_selection", int'(dut_sel()), int'(e_sel));
    check("model_turn", int'(selected_turn), e_turn);
    check("model_last", int'(last_turn), (n == DEPTH) ? 1 : 0);
  endtask

  // Compare process, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      compare_model();
    end
  end

  // Driver tasks: inputs change 2 time units after the rising edge.
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_guess(int a, int b, int c, int d);
    guess0 = W'(a); guess1 = W'(b); guess2 = W'(c); guess3 = W'(d);
  endtask

  task automatic pulse_select();
    btn_select = 1'b1; tick(1);
    btn_select = 1'b0; tick(1);
  endtask

  task automatic pulse_up();
    btn_up = 1'b1; tick(1);
    btn_up = 1'b0; tick(1);
  endtask

  task automatic pulse_down();
    btn_down = 1'b1; tick(1);
    btn_down = 1'b0; tick(1);
  endtask

  task automatic expect_out(string name, logic [SW-1:0] sel, int turn, int last);
    #1;
    check({name, "_sel"},  int'(dut_sel()), int'(sel));
    check({name, "_turn"}, int'(selected_turn), turn);
    check({name, "_last"}, int'(last_turn), last);
  endtask

  // Directed scenarios
  initial begin
    set_guess(1, 0, 0, 0);
    tick(3);
    expect_out("in_reset", pack(1, 0, 0, 0), 0, 0);
    reset = 1'b1;
    tick(1);
    expect_out("after_reset", pack(1, 0, 0, 0), 0, 0);

    pulse_select();
    expect_out("first_commit", pack(1, 0, 0, 0), 1, 0);

    set_guess(0, 1, 0, 0);
    btn_select = 1'b1; tick(5);
    btn_select = 1'b0; tick(1);
    expect_out("held_select", pack(0, 1, 0, 0), 2, 0);

    mode = 1'b1; tick(1);
    expect_out("hist_entry", pack(0, 1, 0, 0), 1, 0);
    pulse_down();
    expect_out("hist_down", pack(1, 0, 0, 0), 0, 0);
    pulse_down();
    expect_out("hist_down_sat", pack(1, 0, 0, 0), 0, 0);
    pulse_up();
    pulse_up();
    expect_out("hist_up_sat", pack(0, 1, 0, 0), 1, 0);
    btn_up = 1'b1; btn_down = 1'b1; tick(1);
    btn_up = 1'b0; btn_down = 1'b0; tick(1);
    expect_out("hist_both", pack(0, 1, 0, 0), 1, 0);
    pulse_select();
    mode = 1'b0; tick(1);
    expect_out("hist_select_ignored", pack(0, 1, 0, 0), 2, 0);
    pulse_up();
    pulse_down();
    expect_out("guess_updown_ignored", pack(0, 1, 0, 0), 2, 0);

    for (int i = 2; i < DEPTH; i++) begin
      set_guess(i, i ^ 1, i ^ 2, 3);
      pulse_select();
    end
    expect_out("full", pack(7, 6, 5, 3), 7, 1);
    set_guess(1, 1, 1, 1);
    pulse_select();
    expect_out("ninth_ignored", pack(1, 1, 1, 1), 7, 1);
    mode = 1'b1; tick(1);
    expect_out("last_stored", pack(7, 6, 5, 3), 7, 1);
    pulse_down();
    expect_out("seventh_stored", pack(6, 7, 4, 3), 6, 1);

    reset = 1'b0;
    expect_out("async_reset", '0, 0, 0);
    tick(2);
    reset = 1'b1; tick(1);
    expect_out("hist_empty", '0, 0, 0);

    mode = 1'b0;
    set_guess(5, 4, 3, 2);
    tick(1);
    expect_out("empty_guess_mode", pack(5, 4, 3, 2), 0, 0);
    pulse_select();
    mode = 1'b1; tick(1);
    expect_out("commit_after_reset", pack(5, 4, 3, 2), 0, 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/guess_history.md
GUESS_HISTORY -- requirements
Module: guess_history

Interface
REQ-001 Parameter DEPTH, default 8, number of stored turns (must equal 2^width(selected_turn)).
REQ-002 Parameter W, default 3, bits per guess peg (colour code).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 mode  input  1  0 = guess mode, 1 = history-browse mode.
REQ-006 btn_up  input  1  browse to newer turn (history mode only).
REQ-007 btn_down  input  1  browse to older turn (history mode only).
REQ-008 btn_select  input  1  commit current guess (guess mode only).
REQ-009 guess0..guess3  input  W each  current guess pegs 0..3.
REQ-010 selection0..selection3  output  W each  displayed pegs 0..3.
REQ-011 selected_turn  output  3  turn index being displayed or entered.
REQ-012 last_turn  output  1  high when all DEPTH turns are stored (game over).

Function
REQ-013 The block SHALL hold a DEPTH x 4 x W guess memory, a 4-bit stored-turn count (0..DEPTH) and a 3-bit view index.
REQ-014 All three buttons SHALL be rising-edge detected via one registered copy each; a held button SHALL act exactly once.
REQ-015 Guess mode: selectionN SHALL equal guessN combinationally (zero latency).
REQ-016 Guess mode: selected_turn SHALL equal count[2:0] while count<DEPTH, and DEPTH-1 when count==DEPTH.
REQ-017 Guess mode, select edge, count<DEPTH: on that clock edge the four guess inputs SHALL be written to memory[count], and count SHALL increment by 1.
REQ-018 Select edge with count==DEPTH SHALL be ignored (no write, no wrap).
REQ-019 last_turn SHALL be a combinational decode of count==DEPTH, independent of mode.
REQ-020 Up/down edges in guess mode SHALL be ignored; select edges in history mode SHALL be ignored.
REQ-021 On the clock edge where mode is sampled 0->1, view SHALL load max(count-1,0) (most recent turn).
REQ-022 History mode: up edge SHALL increment view, saturating at max(count-1,0); down edge SHALL decrement view, saturating at 0.
REQ-023 Simultaneous up and down edges SHALL leave view unchanged.
REQ-024 History mode: selectionN SHALL equal memory[view] pegN; selected_turn SHALL equal view.
REQ-025 History mode with count==0: selectionN SHALL be 0 and selected_turn SHALL be 0.
REQ-026 Returning to guess mode SHALL not alter memory or count.

Reset
REQ-027 reset low SHALL asynchronously clear count, view, memory and all button edge registers to 0.
REQ-028 During/after reset: selected_turn=0, last_turn=0, selectionN=guessN (mode 0) or 0 (mode 1).
REQ-029 Reset mid-game SHALL discard all stored turns; the next commit SHALL write turn 0.

Structure
REQ-030 DEPTH, W and the peg count (4) SHALL be constants in a shared game package used by all game blocks.
REQ-031 One sub-module, btn_edge (registered rising-edge detector), SHALL be instantiated once per button.

Verification
REQ-032 Reset, mode=0, guess=1-0-0-0 -> selection 1-0-0-0, selected_turn 0, last_turn 0.
REQ-033 Pulse select 1 cycle -> next cycle selected_turn 1; guess=0-1-0-0 with select held 5 cycles -> exactly one commit, selected_turn 2.
REQ-034 After those two commits, mode=1 -> selection 0-1-0-0, turn 1; pulse down -> 1-0-0-0, turn 0; pulse down again -> stays turn 0; pulse up twice -> turn 1 (saturates).
REQ-035 Commit 8 guesses -> last_turn 1, selected_turn 7; ninth select -> memory[7] and count unchanged.
REQ-036 mode=1 with no commits -> selection 0-0-0-0, turn 0; assert reset mid-game -> count 0, last_turn 0 immediately, without a clock edge.
